// File: rtl/scanline_pkg.sv
// Shared types, constants and clamp helpers for the scanline sequencer.
package scanline_pkg;

    localparam logic [8:0] ONE_TO_ONE    = 9'd256;
    localparam logic [1:0] MAX_THICKNESS = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

    typedef struct packed {
        logic       enable;
        logic       phase;
        logic [1:0] thickness;
        logic [8:0] intensity;
        logic [7:0] step;
    } scan_cfg_t;

    localparam scan_cfg_t CFG_RESET = '{
        enable:    1'b0,
        phase:     1'b0,
        thickness: 2'd1,
        intensity: ONE_TO_ONE,
        step:      8'd0
    };

    // Zero thickness would give a zero-length period, so it is promoted to one line.
    function automatic logic [1:0] clamp_thickness(input logic [1:0] t);
        logic [1:0] r;
        if (t == 2'd0) begin
            r = 2'd1;
        end else if (t > MAX_THICKNESS) begin
            r = MAX_THICKNESS;
        end else begin
            r = t;
        end
        return r;
    endfunction

    function automatic logic [8:0] clamp_intensity(input logic [8:0] a);
        logic [8:0] r;
        if (a > ONE_TO_ONE) begin
            r = ONE_TO_ONE;
        end else begin
            r = a;
        end
        return r;
    endfunction

endpackage

// File: rtl/scanline_ramp.sv
// Saturating alpha stepper: moves cur toward tgt by at most step per tick.
module scanline_ramp
    import scanline_pkg::*;
(
    input  logic       i_tick,
    input  logic [8:0] i_cur,
    input  logic [8:0] i_tgt,
    input  logic [7:0] i_step,
    output logic [8:0] o_next_cur,
    output logic       o_done
);

    logic [9:0] w_sum;
    logic [9:0] w_gap_down;

    assign w_sum      = {1'b0, i_cur} + {2'b00, i_step};
    assign w_gap_down = {1'b0, i_cur} - {1'b0, i_tgt};

    // Next alpha: compare against the remaining gap so the result never overshoots or wraps.
    always_comb begin
        o_next_cur = i_cur;
        if (!i_tick) begin
            o_next_cur = i_cur;
        end else if (i_step == 8'd0) begin
            o_next_cur = i_tgt;
        end else if (i_cur < i_tgt) begin
            if (w_sum >= {1'b0, i_tgt}) begin
                o_next_cur = i_tgt;
            end else begin
                o_next_cur = w_sum[8:0];
            end
        end else if (i_cur > i_tgt) begin
            if ({2'b00, i_step} >= w_gap_down) begin
                o_next_cur = i_tgt;
            end else begin
                o_next_cur = i_cur - {1'b0, i_step};
            end
        end else begin
            o_next_cur = i_tgt;
        end
    end

    assign o_done = (o_next_cur == i_tgt);

endmodule

// File: rtl/scanline_ctrl.sv
// Scanline sequencer: frame-boundary config shadowing, line-period counter,
// per-line dark flag and frame-stable ramped alpha for the scanline filter.
module scanline_ctrl
    import scanline_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       line_start,
    input  logic       cfg_valid,
    input  logic       cfg_enable,
    input  logic       cfg_phase,
    input  logic [1:0] cfg_thickness,
    input  logic [8:0] cfg_intensity,
    input  logic [7:0] cfg_ramp_step,
    output logic       cfg_ack,
    output logic       busy,
    output logic       isScanline,
    output logic [8:0] scanline_intensity
);

    scan_cfg_t   r_shadow;
    scan_cfg_t   r_active;
    logic        r_pending;
    logic [8:0]  r_cur;
    logic [2:0]  r_cnt;
    ramp_state_e r_state;
    logic        r_isl;
    logic [8:0]  r_int;
    logic        r_ack;
    logic        r_busy;

    scan_cfg_t   w_act_nxt;
    scan_cfg_t   w_cfg_in;
    logic [8:0]  w_cur_nxt;
    logic        w_done;
    ramp_state_e w_state_nxt;
    logic [2:0]  w_period;
    logic [2:0]  w_cnt_nxt;
    logic        w_isl_nxt;

    assign w_cfg_in = '{
        enable:    cfg_enable,
        phase:     cfg_phase,
        thickness: clamp_thickness(cfg_thickness),
        intensity: clamp_intensity(cfg_intensity),
        step:      cfg_ramp_step
    };

    // Active config as seen after this cycle's frame boundary (pending shadow wins).
    always_comb begin
        w_act_nxt = r_active;
        if (frame_start && r_pending) begin
            w_act_nxt = r_shadow;
        end else begin
            w_act_nxt = r_active;
        end
    end

    scanline_ramp u_ramp (
        .i_tick     (frame_start),
        .i_cur      (r_cur),
        .i_tgt      (w_act_nxt.intensity),
        .i_step     (w_act_nxt.step),
        .o_next_cur (w_cur_nxt),
        .o_done     (w_done)
    );

    // Ramp FSM next state, re-evaluated only at frame boundaries.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, RAMP: begin
                if (frame_start) begin
                    w_state_nxt = w_done ? IDLE : RAMP;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_period = {w_act_nxt.thickness, 1'b0};

    // Line counter and dark-line decision; frame_start beats a coincident line_start.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (frame_start) begin
            w_cnt_nxt = 3'd0;
        end else if (line_start) begin
            if (r_cnt == (w_period - 3'd1)) begin
                w_cnt_nxt = 3'd0;
            end else begin
                w_cnt_nxt = r_cnt + 3'd1;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
        w_isl_nxt = w_act_nxt.enable &
                    ((w_cnt_nxt >= {1'b0, w_act_nxt.thickness}) ^ w_act_nxt.phase);
    end

    // Config shadow and apply path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow  <= CFG_RESET;
            r_active  <= CFG_RESET;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_active <= w_act_nxt;
            r_ack    <= frame_start & r_pending;
            if (cfg_valid) begin
                r_shadow  <= w_cfg_in;
                r_pending <= 1'b1;
            end else if (frame_start) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Ramp state register and background alpha.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cur   <= ONE_TO_ONE;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == RAMP);
            r_cur   <= w_cur_nxt;
        end
    end

    // Line counter and filter-facing outputs; alpha only moves at a frame boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 3'd0;
            r_isl <= 1'b0;
            r_int <= ONE_TO_ONE;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (frame_start || line_start) begin
                r_isl <= w_isl_nxt;
            end
            if (frame_start) begin
                r_int <= w_act_nxt.enable ? w_cur_nxt : ONE_TO_ONE;
            end
        end
    end

    assign cfg_ack            = r_ack;
    assign busy               = r_busy;
    assign isScanline         = r_isl;
    assign scanline_intensity = r_int;

endmodule

// File: doc/scanline_ctrl.md
Name: scanline_ctrl

Overview:
- Sequencer for the scanline alpha filter: generates per-line `isScanline` and a frame-stable `scanline_intensity` for the scanline filter stage.
- Config from the OSD/control side is shadowed and applied only at frame boundaries, so no mid-frame tearing.
- Intensity changes ramp frame-by-frame toward the target.
- Sits between the video timing generator (frame/line pulses) and the scanline filter.

Parameters:
- ONE_TO_ONE, 9'd256, unity alpha (no darkening).
- MAX_THICKNESS, 3, largest supported dark-band height in lines.

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of the first active line of a frame
- line_start  in  1  one-cycle pulse at start of every line
- cfg_valid  in  1  one-cycle pulse; capture the cfg_* inputs
- cfg_enable  in  1  scanlines on/off
- cfg_phase  in  1  0: dark band is the second half of the period; 1: first half
- cfg_thickness  in  2  dark lines per band; 0 is treated as 1; values above MAX_THICKNESS clamp to MAX_THICKNESS
- cfg_intensity  in  9  target alpha; values above 256 clamp to 256
- cfg_ramp_step  in  8  alpha change per frame; 0 means instant
- cfg_ack  out  1  one-cycle pulse, the cycle after a pending config is applied
- busy  out  1  high while the ramp has not reached target
- isScanline  out  1  registered: current line is a dark line
- scanline_intensity  out  9  registered alpha fed to the filter

Behaviour:
- Reset (async, reset_n=0):
  - cur=256, tgt=256, active thickness T=1, phase=0, enable=0.
  - pending=0, line cnt=0, state IDLE.
  - Outputs: isScanline=0, scanline_intensity=256, cfg_ack=0, busy=0.
  - Reset mid-frame discards pending config and any ramp in progress.
- Capture:
  - cfg_valid loads shadow regs and sets pending.
  - A later cfg_valid before apply overwrites the shadow (last write wins).
- Apply:
  - On frame_start with pending=1: shadow → active (enable, phase, T, tgt, step); pending cleared; cfg_ack=1 on the next cycle.
  - cfg_valid in the same cycle as frame_start is captured to the shadow and applied at the following frame_start. The current pending value, if any, is applied now.
- Line counter:
  - Period P=2*T. frame_start sets cnt=0; it takes priority if line_start coincides.
  - line_start alone: cnt = (cnt==P-1) ? 0 : cnt+1.
  - T changes only at frame_start, and cnt is reset at that point.
- isScanline:
  - Registered; updated the cycle after frame_start or line_start.
  - Value = enable & ((cnt>=T) ^ phase), using the cnt after the update.
  - Stable for the rest of the line.
- Ramp FSM, states IDLE and RAMP, evaluated at every frame_start after apply (same cycle):
  - step==0: cur=tgt, state=IDLE.
  - cur<tgt: cur = min(cur+step, tgt).
  - cur>tgt: cur = max(cur-step, tgt), using 10-bit intermediate math; no wrap below 0 or above 256.
  - state = (new cur==tgt) ? IDLE : RAMP. busy = (state==RAMP).
- scanline_intensity:
  - enable ? cur : ONE_TO_ONE.
  - Updates only on the cycle after frame_start, so it is constant within a frame.
  - Disabling forces 256 immediately at that frame; cur keeps ramping in the background.
- Latency: frame_start → new intensity/isScanline = 1 cycle; line_start → isScanline = 1 cycle.
- No pulses at all: outputs hold indefinitely.

Decomposition:
- Package scanline_pkg holds:
  - ONE_TO_ONE, MAX_THICKNESS
  - state enum {IDLE, RAMP}
  - config struct {enable, phase, thickness[1:0], intensity[8:0], step[7:0]}
  - clamp helper functions
- Sub-module scanline_ramp: saturating stepper (cur, tgt, step, tick → next cur, done). Keeps the top block to counter + shadow + FSM glue.

Test Plan:
- Reset, then enable=1, phase=0, T=1, intensity=128, step=0; cfg_valid; frame_start → cfg_ack the cycle after; intensity=128; isScanline sequence over lines 0,1,2,3 = 0,1,0,1.
- T=2, phase=1, 6 lines → isScanline 1,1,0,0,1,1; T=0 behaves as T=1; T=3 gives 3 on / 3 off.
- cur=256, tgt=100, step=64 → per frame 192,128,100; busy high for first two frames, low after third.
- cfg_valid coincident with frame_start carrying intensity=50 while pending holds 200 → 200 applied now, 50 at next frame_start, two cfg_ack pulses.
- frame_start and line_start in same cycle → cnt=0, no increment; cfg_intensity=300 → tgt=256.
- reset_n low mid-ramp → all outputs back to reset values asynchronously; pending config is not applied at the next frame_start.
